// File: rtl/ex_wb_stage_pkg.sv
// Shared constants for the execute/writeback stage and its register file.
package ex_wb_stage_pkg;
   localparam int DATA_W = 8;
   localparam int ADDR_W = 3;
   localparam int NREGS  = 8;

   localparam logic WMUX_MOV = 1'b0;
   localparam logic WMUX_ADD = 1'b1;
endpackage

// File: rtl/ex_wb_stage_regfile_bypass.sv
// Architectural register file with one synchronous write port and two
// combinational read ports that see the pending writeback value.
module regfile_bypass #(
   parameter int DATA_W = ex_wb_stage_pkg::DATA_W,
   parameter int ADDR_W = ex_wb_stage_pkg::ADDR_W,
   parameter int NREGS  = ex_wb_stage_pkg::NREGS
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [ADDR_W-1:0] raddr_a,
   input  logic [ADDR_W-1:0] raddr_b,
   output logic [DATA_W-1:0] rdata_a,
   output logic [DATA_W-1:0] rdata_b
);
   logic [DATA_W-1:0] regs [NREGS];

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      end else if (we) begin
         regs[waddr] <= wdata;
      end
   end

   // The write port carries the EX/WB entry, so it doubles as the bypass source.
   always_comb begin
      rdata_a = regs[raddr_a];
      rdata_b = regs[raddr_b];
      if (we && (waddr == raddr_a)) rdata_a = wdata;
      if (we && (waddr == raddr_b)) rdata_b = wdata;
   end
endmodule

// File: rtl/ex_wb_stage.sv
// Execute + writeback stage: operand forwarding, MOV/ADD ALU, EX/WB register
// and register file commit with bypassed ID read ports.
module ex_wb_stage #(
   parameter int DATA_W = ex_wb_stage_pkg::DATA_W,
   parameter int ADDR_W = ex_wb_stage_pkg::ADDR_W,
   parameter int NREGS  = ex_wb_stage_pkg::NREGS
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [DATA_W-1:0] ex_rsdata,
   input  logic [DATA_W-1:0] ex_rddata,
   input  logic [ADDR_W-1:0] ex_rs,
   input  logic [ADDR_W-1:0] ex_rd,
   input  logic              ex_write_mux,
   input  logic              ex_regwrite,
   input  logic [ADDR_W-1:0] id_raddr_a,
   input  logic [ADDR_W-1:0] id_raddr_b,
   output logic [DATA_W-1:0] id_rdata_a,
   output logic [DATA_W-1:0] id_rdata_b,
   output logic [ADDR_W-1:0] wb_rd,
   output logic [DATA_W-1:0] wb_data,
   output logic              wb_regwrite,
   output logic              fwd_rs,
   output logic              fwd_rd,
   output logic [7:0]        retire_count
);
   import ex_wb_stage_pkg::*;

   logic [DATA_W-1:0] rs_op;
   logic [DATA_W-1:0] rd_op;
   logic [DATA_W-1:0] sum;
   logic [DATA_W-1:0] result;

   always_comb begin
      fwd_rs = wb_regwrite && (wb_rd == ex_rs);
      fwd_rd = wb_regwrite && (wb_rd == ex_rd);
      rs_op  = fwd_rs ? wb_data : ex_rsdata;
      rd_op  = fwd_rd ? wb_data : ex_rddata;
   end

   // Carry out of the add is intentionally dropped.
   assign sum = rs_op + rd_op;

   always_comb begin
      case (ex_write_mux)
         WMUX_MOV: result = rs_op;
         WMUX_ADD: result = sum;
         default:  result = rs_op;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         wb_rd        <= '0;
         wb_data      <= '0;
         wb_regwrite  <= 1'b0;
         retire_count <= '0;
      end else begin
         wb_rd       <= ex_rd;
         wb_data     <= result;
         wb_regwrite <= ex_regwrite;
         if (wb_regwrite) retire_count <= retire_count + 8'd1;
      end
   end

   regfile_bypass #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .NREGS  (NREGS)
   ) u_regfile (
      .clock   (clock),
      .reset   (reset),
      .we      (wb_regwrite),
      .waddr   (wb_rd),
      .wdata   (wb_data),
      .raddr_a (id_raddr_a),
      .raddr_b (id_raddr_b),
      .rdata_a (id_rdata_a),
      .rdata_b (id_rdata_b)
   );
endmodule

// File: doc/ex_wb_stage.md
Name: ex_wb_stage

Overview:
- Execute plus writeback stage. Sits directly downstream of the ID/EX pipeline register and consumes its Rs/Rd data, register indices and control bits.
- Forwards its own in-flight result back into EX operands and computes MOV/ADD results.
- Holds the EX/WB pipeline register and the 8x8 architectural register file, with bypassed read ports serving the ID stage.

Parameters:
- DATA_W, 8, datapath and register width
- ADDR_W, 3, register index width
- NREGS, 8, register count (must equal 2**ADDR_W)

Ports:
- clock  in  1  single clock; all state updates on posedge
- reset  in  1  synchronous, active-high reset
- ex_rsdata  in  DATA_W  Rs operand value from ID/EX
- ex_rddata  in  DATA_W  Rd operand value from ID/EX
- ex_rs  in  ADDR_W  Rs index from ID/EX
- ex_rd  in  ADDR_W  Rd index (destination) from ID/EX
- ex_write_mux  in  1  0 = MOV (result = Rs), 1 = ADD (result = Rs + Rd)
- ex_regwrite  in  1  instruction writes Rd
- id_raddr_a  in  ADDR_W  ID read port A index
- id_raddr_b  in  ADDR_W  ID read port B index
- id_rdata_a  out  DATA_W  port A data, bypassed
- id_rdata_b  out  DATA_W  port B data, bypassed
- wb_rd  out  ADDR_W  EX/WB destination index
- wb_data  out  DATA_W  EX/WB result
- wb_regwrite  out  1  EX/WB write enable
- fwd_rs  out  1  Rs operand taken from forward path this cycle
- fwd_rd  out  1  Rd operand taken from forward path this cycle
- retire_count  out  8  number of committed register writes

Behaviour:
- Reset (synchronous, active-high, highest priority):
  - wb_rd, wb_data, wb_regwrite, retire_count and all NREGS registers go to 0.
  - An EX/WB entry in flight at reset is discarded; no register file write occurs on that edge.
- Forwarding (combinational):
  - rs_op = wb_data if (wb_regwrite && wb_rd == ex_rs), else ex_rsdata; fwd_rs mirrors the select.
  - rd_op selected the same way against ex_rd; fwd_rd mirrors the select.
- ALU (combinational):
  - result = rs_op when ex_write_mux = 0.
  - result = (rs_op + rd_op) mod 2**DATA_W when ex_write_mux = 1; carry is dropped.
- EX/WB register, each posedge when not in reset:
  - wb_rd <= ex_rd, wb_data <= result, wb_regwrite <= ex_regwrite.
  - Latency from EX inputs to wb_* outputs is 1 cycle.
- Register file commit, same posedge:
  - If wb_regwrite = 1, regs[wb_rd] <= wb_data and retire_count increments, wrapping 255 -> 0.
  - Commit uses the old wb_* values, concurrently with the EX/WB update, so a result reaches the register file 2 cycles after EX.
- ID read ports (combinational):
  - id_rdata_x = wb_data if (wb_regwrite && wb_rd == id_raddr_x), else regs[id_raddr_x].
- Hazard coverage, with no stalls required:
  - Distance 1 (consumer in EX while producer in WB): EX forward.
  - Distance 2 (consumer in ID while producer in WB): read bypass.
  - Distance 3 or more: register file.
- Boundary cases:
  - ex_rs == ex_rd == wb_rd: both operands forward (ADD doubles wb_data).
  - ex_regwrite = 0: EX/WB still latches data, but no commit, no forwarding and no count increment.
  - All registers, including index 0, are writable.
  - Index wrap: ADDR_W bits compare exactly; there is no out-of-range case.
- First cycle after reset release: EX/WB holds a zero entry with wb_regwrite = 0; no commit.

Decomposition:
- Shared package:
  - DATA_W, ADDR_W, NREGS constants.
  - Write-mux encodings WMUX_MOV = 1'b0 and WMUX_ADD = 1'b1.
- One natural sub-module: regfile_bypass.
  - Contains the NREGS x DATA_W array, the synchronous write port, and two combinational read ports with WB bypass.
- Forwarding, ALU and the EX/WB register stay in the top level.

Test Plan:
- Reset: hold reset 2 cycles mid-traffic, with wb_regwrite = 1 pending for r3 = 0x55. Required: wb_* = 0, retire_count = 0, id_rdata_a(r3) = 0x00, and r3 is never written.
- MOV: ex_rs = 1, ex_rsdata = 0x3C, ex_rd = 2, mux = 0, regwrite = 1. Required: next cycle wb_data = 0x3C, wb_rd = 2; following cycle regs[2] = 0x3C, retire_count = 1.
- ADD wrap: rsdata = 0xF0, rddata = 0x20, mux = 1, rd = 4. Required: wb_data = 0x10.
- Distance-1 forward:
  - Setup: the instruction in WB wrote r5 = 0x07.
  - Stimulus: ADD with rs = 5 (stale ex_rsdata = 0x00), rd = 6, rddata = 0x01.
  - Required: fwd_rs = 1 and result 0x08.
- Distance-2 bypass: wb_rd = 5, wb_data = 0x07, wb_regwrite = 1, id_raddr_b = 5. Required: id_rdata_b = 0x07 before commit.
- Double forward and no-write: ex_rs = ex_rd = wb_rd = 1, wb_data = 0x40, ADD. Required: result 0x80, fwd_rs = fwd_rd = 1. Then the same with wb_regwrite = 0: operands are taken from the ex_* inputs and retire_count is unchanged.
